// File: rtl/des_core_arbiter.sv
// rtl/des_core_arbiter.sv - round-robin arbiter sharing one iterative DES core among requesters
// One job in flight at a time; a watchdog forces an error response if the core never completes.
module des_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_encrypt,
  input  logic [NUM_REQ*64-1:0]  req_data,
  input  logic [NUM_REQ*64-1:0]  req_key,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [63:0]            resp_data,
  output logic                   resp_error,
  output logic                   core_start,
  output logic                   core_encrypt,
  output logic [63:0]            core_data_in,
  output logic [63:0]            core_key,
  input  logic [63:0]            core_data_out,
  input  logic                   core_done,
  input  logic                   core_error,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             pick_found;
  logic [TMR_W-1:0] timer;
  logic             timeout;
  logic             grant_live;
  logic             resp_take;
  logic             sel_encrypt;
  logic [63:0]      sel_data;
  logic [63:0]      sel_key;

  // Scan starts just after the last completed grant so every requester gets a turn.
  always_comb begin
    pick       = last_grant;
    cand       = last_grant;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_encrypt = 1'b0;
    sel_data    = '0;
    sel_key     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_encrypt = req_encrypt[i];
        sel_data    = req_data[i*64 +: 64];
        sel_key     = req_key[i*64 +: 64];
      end
    end
  end

  assign grant_live = req_valid[grant_idx];
  assign resp_take  = resp_ready[grant_idx];
  assign timeout    = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = GRANT;
      end
      GRANT: begin
        if (grant_live) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done || timeout) state_nxt = RESP;
      end
      RESP: begin
        resp_valid[grant_idx] = 1'b1;
        if (resp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_idx    <= '0;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      timer        <= '0;
      core_encrypt <= 1'b0;
      core_data_in <= '0;
      core_key     <= '0;
      resp_data    <= '0;
      resp_error   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_found) grant_idx <= pick;
        end
        GRANT: begin
          if (grant_live) begin
            core_encrypt <= sel_encrypt;
            core_data_in <= sel_data;
            core_key     <= sel_key;
          end
        end
        ISSUE: begin
          timer <= '0;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // A completion landing on the timeout cycle still delivers the real result.
          if (core_done) begin
            resp_data  <= core_data_out;
            resp_error <= core_error;
          end else if (timeout) begin
            resp_data  <= '0;
            resp_error <= 1'b1;
          end
        end
        RESP: begin
          if (resp_take) last_grant <= grant_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_core_arbiter.sv
// tb/tb_des_core_arbiter.sv - directed self-checking bench for des_core_arbiter
// Drives inputs on the falling edge and samples outputs there, away from the active edge.
module tb_des_core_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, req_encrypt, resp_valid, resp_ready;
  logic [N*64-1:0]   req_data, req_key;
  logic [63:0]       resp_data, core_data_in, core_key, core_data_out;
  logic              resp_error, core_start, core_encrypt, core_done, core_error, busy;
  logic [1:0]        grant_idx;

  logic              model_en = 1'b0;
  logic              model_done = 1'b0;
  logic              xor_mode = 1'b0;
  logic              force_done = 1'b0;
  logic              force_err = 1'b0;
  logic [63:0]       fixed_out = '0;
  logic [63:0]       force_data = '0;
  int                lat = 16;
  int                cnt = 0;
  int                ready_pulses = 0;
  int                checks = 0;
  int                failures = 0;

  des_core_arbiter #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_encrypt(req_encrypt),
    .req_data(req_data), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error),
    .core_start(core_start), .core_encrypt(core_encrypt),
    .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out), .core_done(core_done), .core_error(core_error),
    .busy(busy), .grant_idx(grant_idx)
  );

  // Core stand-in: fixed answer or data^key, completing lat cycles after the start pulse.
  assign core_done     = model_done | force_done;
  assign core_error    = force_done & force_err;
  assign core_data_out = force_done ? force_data : (xor_mode ? (core_data_in ^ core_key) : fixed_out);

  always @(negedge clk) begin
    model_done = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) model_done = 1'b1;
    end
    if (core_start && model_en) cnt = lat;
  end

  always @(posedge clk) begin
    if (rst_n && (req_ready != '0)) ready_pulses = ready_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return |req_ready;
      1:       return |resp_valid;
      default: return core_start;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_of(which) && n < budget);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int          n;
    int          g;
    int          pulses0;
    bit          ok;
    logic [63:0] exp_bp;

    rst_n = 1'b0; req_valid = '0; req_encrypt = '0; req_data = '0; req_key = '0; resp_ready = '0;
    model_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_core_start", 64'(core_start), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_error", 64'(resp_error), 0);
    chk("rst_core_data_in", core_data_in, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_encrypt", 64'(core_encrypt), 0);

    // Single job on requester 0.
    rst_n = 1'b1;
    req_data[63:0] = 64'h0123456789ABCDEF;
    req_key[63:0]  = 64'h133457799BBCDFF1;
    req_encrypt    = 4'b0001;
    fixed_out      = 64'h85E813540F0AB405;
    req_valid      = 4'b0001;
    @(negedge clk);
    chk("t1_req_ready", 64'(req_ready), 64'h1);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_grant_idx", 64'(grant_idx), 0);
    chk("t1_start_early", 64'(core_start), 0);
    @(negedge clk);
    chk("t1_core_start", 64'(core_start), 1);
    chk("t1_ready_gone", 64'(req_ready), 0);
    chk("t1_core_data_in", core_data_in, 64'h0123456789ABCDEF);
    chk("t1_core_key", core_key, 64'h133457799BBCDFF1);
    chk("t1_core_encrypt", 64'(core_encrypt), 1);
    req_valid = '0;
    wait_for(1, 200, n);
    chk("t1_resp_valid", 64'(resp_valid), 64'h1);
    chk("t1_resp_data", resp_data, 64'h85E813540F0AB405);
    chk("t1_resp_error", 64'(resp_error), 0);
    resp_ready = 4'b0001;
    @(negedge clk);
    chk("t1_idle", 64'(busy), 0);
    chk("t1_resp_dropped", 64'(resp_valid), 0);
    resp_ready = '0;

    // Reset so requester 0 wins first, then rotate with everyone requesting.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xor_mode = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_data[i*64 +: 64] = 64'h0123456789ABCDEF + 64'(i) * 64'h1111;
      req_key[i*64 +: 64]  = 64'hF0E1D2C3B4A59687 + 64'(i);
    end
    req_encrypt = 4'b1010;
    resp_ready  = 4'hF;
    pulses0     = ready_pulses;
    req_valid   = 4'hF;
    for (int j = 0; j < 8; j++) begin
      g = j % N;
      wait_for(0, 50, n);
      chk("rr_req_ready", 64'(req_ready), 64'(1 << g));
      chk("rr_grant_idx", 64'(grant_idx), 64'(g));
      if (j == 7) begin
        @(negedge clk);
        req_valid = '0;
      end
      wait_for(1, 100, n);
      chk("rr_resp_valid", 64'(resp_valid), 64'(1 << g));
      chk("rr_resp_data", resp_data, req_data[g*64 +: 64] ^ req_key[g*64 +: 64]);
      chk("rr_encrypt", 64'(core_encrypt), 64'(req_encrypt[g]));
    end
    repeat (2) @(negedge clk);
    chk("rr_pulses", 64'(ready_pulses - pulses0), 8);
    chk("rr_idle", 64'(busy), 0);

    // Watchdog: core never completes.
    model_en  = 1'b0;
    req_valid = 4'b0100;
    wait_for(0, 50, n);
    chk("to_req_ready", 64'(req_ready), 64'h4);
    wait_for(2, 10, n);
    chk("to_core_start", 64'(core_start), 1);
    req_valid = '0;
    wait_for(1, 200, n);
    chk("to_wait_cycles", 64'(n), 65);
    chk("to_resp_valid", 64'(resp_valid), 64'h4);
    chk("to_resp_data", resp_data, 0);
    chk("to_resp_error", 64'(resp_error), 1);

    // Normal service after the timeout.
    model_en  = 1'b1;
    req_valid = 4'b1000;
    wait_for(2, 50, n);
    req_valid = '0;
    wait_for(1, 100, n);
    chk("post_to_resp_valid", 64'(resp_valid), 64'h8);
    chk("post_to_resp_data", resp_data, req_data[3*64 +: 64] ^ req_key[3*64 +: 64]);
    chk("post_to_resp_error", 64'(resp_error), 0);
    @(negedge clk);

    // Back-pressure on requester 1 while requester 3 waits.
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    wait_for(0, 50, n);
    chk("bp_req_ready", 64'(req_ready), 64'h2);
    wait_for(2, 10, n);
    req_valid = 4'b1000;
    exp_bp    = req_data[1*64 +: 64] ^ req_key[1*64 +: 64];
    wait_for(1, 100, n);
    chk("bp_resp_valid", 64'(resp_valid), 64'h2);
    chk("bp_resp_data", resp_data, exp_bp);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 4'b0010 || resp_data !== exp_bp || req_ready !== 4'b0000 || core_start !== 1'b0)
        ok = 1'b0;
    end
    chk("bp_stable", 64'(ok), 1);
    resp_ready = 4'b0010;
    wait_for(0, 20, n);
    chk("bp_next_grant", 64'(req_ready), 64'h8);
    resp_ready = 4'hF;
    wait_for(2, 10, n);
    req_valid = '0;
    wait_for(1, 100, n);
    chk("bp_next_data", resp_data, req_data[3*64 +: 64] ^ req_key[3*64 +: 64]);
    @(negedge clk);

    // Withdrawal in GRANT.
    req_valid = 4'b0100;
    @(negedge clk);
    chk("wd_req_ready", 64'(req_ready), 64'h4);
    req_valid = '0;
    #1;
    chk("wd_ready_dropped", 64'(req_ready), 0);
    @(negedge clk);
    chk("wd_idle", 64'(busy), 0);
    chk("wd_no_start", 64'(core_start), 0);

    // last_grant kept at 3, so 0 wins; done collides with the timeout cycle.
    model_en  = 1'b0;
    req_valid = 4'hF;
    wait_for(0, 20, n);
    chk("wd_last_grant_kept", 64'(req_ready), 64'h1);
    wait_for(2, 10, n);
    req_valid = '0;
    repeat (64) @(negedge clk);
    force_data = 64'hC0FFEE0012345678;
    force_err  = 1'b0;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("col_resp_valid", 64'(resp_valid), 64'h1);
    chk("col_resp_data", resp_data, 64'hC0FFEE0012345678);
    chk("col_resp_error", 64'(resp_error), 0);
    @(negedge clk);

    // Reset in the middle of WAIT.
    req_valid = 4'b0010;
    wait_for(2, 20, n);
    chk("mr_core_start", 64'(core_start), 1);
    req_valid = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy", 64'(busy), 0);
    chk("mr_resp_valid", 64'(resp_valid), 0);
    chk("mr_core_start", 64'(core_start), 0);
    chk("mr_core_data_in", core_data_in, 0);
    chk("mr_core_key", core_key, 0);
    chk("mr_core_encrypt", 64'(core_encrypt), 0);
    chk("mr_resp_data", resp_data, 0);
    chk("mr_resp_error", 64'(resp_error), 0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 4'b0000 || core_start !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("mr_no_response", 64'(ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
